// File: rtl/ps2_key_gen_if.sv
// PS/2 receiver bus: raw line inputs and decoded key/byte outputs.
interface ps2_key_gen_if;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] ps2_key;
    logic        byte_vld;
    logic [7:0]  byte_out;
    logic        parity_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  ps2_key, byte_vld, byte_out, parity_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output ps2_key, byte_vld, byte_out, parity_err
    );
endinterface

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, frames
// 11-bit PS/2 words, and decodes scan-code sequences into key events.
module ps2_key_gen #(
    parameter logic [15:0] TIMEOUT = 16'd6000,
    parameter int          FILT    = 4
) (
    input  logic      clk,
    input  logic      rst,
    ps2_key_gen_if.slave ps2
);

    localparam int FCW = $clog2(FILT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           bit_evt;

    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [15:0]    tmo_q, tmo_d;
    logic           byte_vld_q, byte_vld_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           perr_q, perr_d;

    logic           ext_q, ext_d;
    logic           rel_q, rel_d;
    logic [2:0]     skip_q, skip_d;
    logic [10:0]    key_q, key_d;

    // Two-stage synchronizers; idle-high lines so reset to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2.ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Clock filter: flip level after FILT consecutive differing samples; a falling flip is a bit event
    always_comb begin
        filt_d  = filt_q;
        fcnt_d  = '0;
        bit_evt = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILT - 1)) begin
                filt_d  = clk_s2_q;
                bit_evt = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Frame FSM next-state: start, 8 data bits LSB-first, odd parity, stop; silent abort on timeout
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        byte_vld_d = 1'b0;
        byte_out_d = byte_out_q;
        perr_d     = 1'b0;

        if (state_q != IDLE && !bit_evt) begin
            tmo_d = tmo_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bit_evt && !dat_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_evt) begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_evt) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_evt) begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_vld_d = 1'b1;
                        byte_out_d = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stalled partial frame: drop it without any pulse
        if (state_q != IDLE && !bit_evt && tmo_q == TIMEOUT - 16'd1) begin
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    // Frame FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            byte_out_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            byte_out_q <= byte_out_d;
            perr_q     <= perr_d;
        end
    end

    // Decoder next-state: prefix tracking (E0/F0), E1 pause-sequence skipping, key word generation
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        if (perr_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else begin
                case (byte_out_q)
                    8'hE1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end
                    8'hE0: ext_d = 1'b1;
                    8'hF0: rel_d = 1'b1;
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                    default: begin
                        key_d = {~key_q[10], ~rel_q, ext_q, byte_out_q};
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Decoder registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
            key_q  <= '0;
        end else begin
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
            key_q  <= key_d;
        end
    end

    assign ps2.ps2_key    = key_q;
    assign ps2.byte_vld   = byte_vld_q;
    assign ps2.byte_out   = byte_out_q;
    assign ps2.parity_err = perr_q;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Scoreboard bench for ps2_key_gen: PS/2 frames are generated on the raw
// lines, a reference model pushes expected events/key words, and a monitor
// pops and compares whenever the DUT pulses or its key word changes.
module tb_ps2_key_gen;

    localparam logic [15:0] TMO  = 16'd400;
    localparam int          FILT = 4;

    typedef struct packed {
        logic       perr;
        logic [7:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_key_gen_if bus();

    ps2_key_gen #(.TIMEOUT(TMO), .FILT(FILT)) dut (
        .clk(clk),
        .rst(rst),
        .ps2(bus.slave)
    );

    always #5 clk = ~clk;

    ev_t         ev_q[$];
    logic [10:0] key_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          half   = 10;

    // Reference model state
    logic        m_ext, m_rel;
    int          m_skip;
    logic [10:0] m_key;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ext = 1'b0; m_rel = 1'b0; m_skip = 0; m_key = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_q.push_back('{perr: 1'b0, val: b});
        if (m_skip > 0) begin
            m_skip--; m_ext = 1'b0; m_rel = 1'b0;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 1'b0; m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            key_q.push_back(m_key);
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic model_perr();
        ev_q.push_back('{perr: 1'b1, val: 8'h00});
        m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_dat = b;
        tick(half);
        bus.ps2_clk = 1'b0;
        tick(half);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        logic par;
        par = (~^b) ^ flip_par;
        if (flip_par || bad_stop) model_perr();
        else model_byte(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(~bad_stop);
        bus.ps2_dat = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (ev_q.size() != 0 || key_q.size() != 0); i++) tick(1);
        tick(10);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ps2_key"}, 32'(bus.ps2_key), 32'h0);
        chk({tag, "_byte_vld"}, 32'(bus.byte_vld), 32'h0);
        chk({tag, "_byte_out"}, 32'(bus.byte_out), 32'h0);
        chk({tag, "_parity_err"}, 32'(bus.parity_err), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick(3);
        check_outputs_zero(tag);
        rst = 1'b0;
        model_reset();
        tick(5);
    endtask

    // Monitor: pop and compare on every pulse and every key-word change
    initial begin
        logic [10:0] last_key;
        logic        prev_vld;
        ev_t         e;
        last_key = '0;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_key = bus.ps2_key;
                prev_vld = 1'b0;
            end else begin
                if (bus.byte_vld || bus.parity_err) begin
                    chk("pulse_exclusive", 32'(bus.byte_vld & bus.parity_err), 32'h0);
                    if (ev_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_pulse: byte_vld=%0b parity_err=%0b byte_out=%0h expected none",
                                 bus.byte_vld, bus.parity_err, bus.byte_out);
                    end else begin
                        e = ev_q.pop_front();
                        chk("pulse_kind_perr", 32'(bus.parity_err), 32'(e.perr));
                        if (!e.perr) chk("byte_out", 32'(bus.byte_out), 32'(e.val));
                    end
                end
                if (bus.ps2_key != last_key) begin
                    chk("key_one_cycle_after_vld", 32'(prev_vld), 32'h1);
                    if (key_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_key_update: got %0h expected no change from %0h",
                                 bus.ps2_key, last_key);
                    end else begin
                        chk("ps2_key", 32'(bus.ps2_key), 32'(key_q.pop_front()));
                    end
                end
                prev_vld = bus.byte_vld;
                last_key = bus.ps2_key;
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0] ign [6];
        logic [7:0] b;
        int         r;
        ign = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        model_reset();
        do_reset("reset");

        // First key press from reset, then extended release
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        drain();

        // Parity error then a good frame
        send_frame(8'h29, 1'b1, 1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        drain();

        // Bad stop bit
        send_frame(8'h1C, 1'b0, 1'b1);
        drain();

        // Partial frame aborted by timeout, then a full frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        bus.ps2_dat = 1'b1;
        tick(int'(TMO) + 20);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Pause sequence skipping
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Short clock glitch with data low must not start a frame
        bus.ps2_dat = 1'b0;
        tick(1);
        bus.ps2_clk = 1'b0;
        tick(FILT - 1);
        bus.ps2_clk = 1'b1;
        tick(2);
        bus.ps2_dat = 1'b1;
        tick(20);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset("midframe_reset");
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Reset after a release prefix
        send_frame(8'hF0, 1'b0, 1'b0);
        drain();
        do_reset("after_f0_reset");
        send_frame(8'h1C, 1'b0, 1'b0);
        drain();

        // Randomized back-to-back traffic
        for (int n = 0; n < 60; n++) begin
            half = int'($urandom_range(8, 14));
            r = int'($urandom_range(0, 9));
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
                3: b = ign[$urandom_range(0, 5)];
                default: b = 8'($urandom);
            endcase
            send_frame(b, ($urandom_range(0, 11) == 0), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 7) == 0) tick(int'($urandom_range(1, 50)));
        end
        drain();

        chk("event_queue_drained", 32'(ev_q.size()), 32'h0);
        chk("key_queue_drained", 32'(key_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
